rr_grant_index: RTL and testbench

Round-robin arbiter for up to 2**N requesters. It produces a registered binary grant index `gnt_idx`, which feeds directly into `decoder_param` (same `N`) to form the one-hot grant vector. A grant is held until the owner signals `release`. The rotating priority pointer then advances past the last winner, so no requester is starved.

---
 rtl/rr_grant_index.sv | 107 ++++++++++
 tb/tb_rr_grant_index.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_index.sv
// rr_grant_index: round-robin arbiter with a registered binary grant index. A grant is held until released.
// Build macro RR_GRANT_BACK2BACK_EN lets a release hand the grant straight to the next winner with no idle cycle.
module rr_grant_index #(
  parameter int N = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [2**N-1:0]   i_req,
  input  logic              i_release,
  output logic              o_gnt_valid,
  output logic [N-1:0]      o_gnt_idx,
  output logic [N-1:0]      o_ptr
);

  localparam int R = 2**N;

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic           r_gnt_valid;
  logic [N-1:0]   r_gnt_idx;
  logic [N-1:0]   r_ptr;
  logic [N-1:0]   w_next_idx;
  logic [N-1:0]   w_next_ptr;

  logic [N-1:0]   w_base;
  logic [R-1:0]   w_req_eff;
  logic [N-1:0]   w_scan_idx;
  logic           w_win_vld;
  logic [N-1:0]   w_win_idx;

  // In the back-to-back build, a grant that is being released searches from
  // the advanced pointer and must not re-select the releasing owner.
  always_comb begin
    w_base    = r_ptr;
    w_req_eff = i_req;
`ifdef RR_GRANT_BACK2BACK_EN
    if (r_state == S_GRANT) begin
      w_base    = r_gnt_idx + N'(1);
      w_req_eff = i_req & ~(R'(1) << r_gnt_idx);
    end
`endif
  end

  // Scan downwards so that the lowest offset from the base wins.
  always_comb begin
    w_win_vld  = 1'b0;
    w_win_idx  = '0;
    w_scan_idx = '0;
    for (int k = R - 1; k >= 0; k--) begin
      w_scan_idx = w_base + N'(k);
      if (w_req_eff[w_scan_idx]) begin
        w_win_vld = 1'b1;
        w_win_idx = w_scan_idx;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_gnt_valid <= 1'b0;
      r_gnt_idx   <= '0;
      r_ptr       <= '0;
    end else begin
      r_state     <= w_next_state;
      r_gnt_valid <= (w_next_state == S_GRANT);
      r_gnt_idx   <= w_next_idx;
      r_ptr       <= w_next_ptr;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_gnt_idx;
    w_next_ptr   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_win_vld) begin
          w_next_state = S_GRANT;
          w_next_idx   = w_win_idx;
        end
      end
      S_GRANT: begin
        if (i_release) begin
          w_next_ptr   = r_gnt_idx + N'(1);
          w_next_state = S_IDLE;
`ifdef RR_GRANT_BACK2BACK_EN
          if (w_win_vld) begin
            w_next_state = S_GRANT;
            w_next_idx   = w_win_idx;
          end
`endif
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_gnt_valid = r_gnt_valid;
    o_gnt_idx   = r_gnt_idx;
    o_ptr       = r_ptr;
  end

endmodule

// File: tb/tb_rr_grant_index.sv
// Directed bench for rr_grant_index (N=3): a reference model checked on every cycle
// plus hand-computed expectations for the reset, rotation, wrap, hold and reset-mid-grant cases.
module tb_rr_grant_index;

  localparam int N = 3;
  localparam int R = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [R-1:0] req;
  logic         rel;
  logic         gnt_valid;
  logic [N-1:0] gnt_idx;
  logic [N-1:0] ptr;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // reference model state
  bit m_busy;
  int m_idx;
  int m_ptr;

  rr_grant_index #(.N(N)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req       (req),
    .i_release   (rel),
    .o_gnt_valid (gnt_valid),
    .o_gnt_idx   (gnt_idx),
    .o_ptr       (ptr)
  );

  always #5 clk = ~clk;

  function automatic int search(input logic [R-1:0] r, input int p);
    for (int k = 0; k < R; k++) begin
      if (r[(p + k) % R]) return (p + k) % R;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    logic [R-1:0] masked;
    masked = '0;
    if (rst) begin
      m_busy = 1'b0;
      m_idx  = 0;
      m_ptr  = 0;
    end else if (!m_busy) begin
      if (req != '0) begin
        m_idx  = search(req, m_ptr);
        m_busy = 1'b1;
      end
    end else if (rel) begin
      m_ptr = (m_idx + 1) % R;
`ifdef RR_GRANT_BACK2BACK_EN
      masked = req;
      masked[m_idx] = 1'b0;
      if (masked != '0) m_idx = search(masked, m_ptr);
      else m_busy = 1'b0;
`else
      m_busy = 1'b0;
`endif
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_gnt_valid", int'(gnt_valid), int'(m_busy));
      check("model_gnt_idx", int'(gnt_idx), m_idx);
      check("model_ptr", int'(ptr), m_ptr);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int exp_g[4] = '{2, 5, 7, 2};
  int exp_p[4] = '{3, 6, 0, 3};

  initial begin
    rst = 1'b1;
    req = 8'hFF;
    rel = 1'b0;
    step();
    chk_on = 1'b1;
    step();
    check("reset_valid", int'(gnt_valid), 0);
    check("reset_idx", int'(gnt_idx), 0);
    check("reset_ptr", int'(ptr), 0);
    rst = 1'b0;
    step();
    check("first_grant_valid", int'(gnt_valid), 1);
    check("first_grant_idx", int'(gnt_idx), 0);

`ifndef RR_GRANT_BACK2BACK_EN
    // release in the very first grant cycle
    rel = 1'b1;
    step();
    rel = 1'b0;
    req = '0;
    check("first_release_valid", int'(gnt_valid), 0);
    check("first_release_ptr", int'(ptr), 1);
    step();

    // rotation with a one-cycle bubble between grants
    req = 8'b1010_0100;
    step();
    for (int i = 0; i < 4; i++) begin
      check("rot_valid", int'(gnt_valid), 1);
      check("rot_idx", int'(gnt_idx), exp_g[i]);
      rel = 1'b1;
      step();
      rel = 1'b0;
      check("rot_bubble", int'(gnt_valid), 0);
      check("rot_ptr", int'(ptr), exp_p[i]);
      if (i == 3) req = '0;
      step();
    end

    // wrap and skip
    req = 8'h20;
    step();
    check("wrap_g5", int'(gnt_idx), 5);
    rel = 1'b1;
    step();
    rel = 1'b0;
    check("wrap_ptr6", int'(ptr), 6);
    req = 8'b0000_0011;
    step();
    check("wrap_g0", int'(gnt_idx), 0);
    rel = 1'b1;
    step();
    rel = 1'b0;
    check("wrap_ptr1", int'(ptr), 1);
    step();
    check("wrap_g1", int'(gnt_idx), 1);
    rel = 1'b1;
    step();
    rel = 1'b0;
    req = '0;
    step();

    // grant held after its request drops
    req = 8'h10;
    step();
    req = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", int'(gnt_valid), 1);
      check("hold_idx", int'(gnt_idx), 4);
    end
    rel = 1'b1;
    step();
    rel = 1'b0;
    check("hold_release_valid", int'(gnt_valid), 0);
    check("hold_release_ptr", int'(ptr), 5);

    // reset wins over release
    req = 8'h08;
    step();
    check("rst_mid_idx3", int'(gnt_idx), 3);
    rel = 1'b1;
    rst = 1'b1;
    step();
    check("rst_mid_valid", int'(gnt_valid), 0);
    check("rst_mid_idx", int'(gnt_idx), 0);
    check("rst_mid_ptr", int'(ptr), 0);
    rst = 1'b0;
    req = '0;
    // release ignored while idle
    step();
    step();
    check("idle_release_valid", int'(gnt_valid), 0);
    check("idle_release_ptr", int'(ptr), 0);
    rel = 1'b0;
    step();
`else
    // back-to-back handoff with no bubble
    rel = 1'b1;
    req = 8'h0F;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("b2b_valid", int'(gnt_valid), 1);
      check("b2b_idx", int'(gnt_idx), i % 4);
    end
    rel = 1'b0;
    req = '0;
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
